pipelined_shift_unit: RTL and testbench

//  Parametrised successor to the fixed shift-left-by-2 block: a WIDTH-bit barrel

---
 rtl/pipelined_shift_unit_pkg.sv | 28 ++
 rtl/pipelined_shift_unit_if.sv | 40 ++++
 rtl/pipelined_shift_unit_stage.sv | 106 ++++++++++
 rtl/pipelined_shift_unit.sv | 80 ++++++++
 tb/tb_pipelined_shift_unit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_shift_unit_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
//   Definitions shared by the pipelined shift unit, its interface and its
//   stages: the 2-bit shift mode encoding and the clog2 helper that derives
//   the shift-amount width (which is also the pipeline depth).
// ----------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_ROTL = 2'b11
    } shift_mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = value - 1;
        while (v != 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipelined_shift_unit_if.sv
// ----------------------------------------------------------------------------
// pipelined_shift_unit_if
//   Operation/result handshake bundle of the pipelined shift unit.
//   master : producer of ops / consumer of results (drives In*, OutReady)
//   slave  : the shift unit (drives InReady, OutValid, OutData, OutTag, OutZero)
//   In*    : InValid/InReady handshake, InData operand, InShamt amount,
//            InMode (SLL/SRL/SRA/ROTL), InTag sideband
//   Out*   : OutValid/OutReady handshake, OutData result, OutTag, OutZero
// ----------------------------------------------------------------------------
interface pipelined_shift_unit_if
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned SHAMT_W = clog2(WIDTH);

    logic               InValid;
    logic               InReady;
    logic [WIDTH-1:0]   InData;
    logic [SHAMT_W-1:0] InShamt;
    logic [1:0]         InMode;
    logic [TAG_W-1:0]   InTag;
    logic               OutValid;
    logic               OutReady;
    logic [WIDTH-1:0]   OutData;
    logic [TAG_W-1:0]   OutTag;
    logic               OutZero;

    modport master (
        output InValid, InData, InShamt, InMode, InTag, OutReady,
        input  InReady, OutValid, OutData, OutTag, OutZero
    );

    modport slave (
        input  InValid, InData, InShamt, InMode, InTag, OutReady,
        output InReady, OutValid, OutData, OutTag, OutZero
    );

endinterface

// File: rtl/pipelined_shift_unit_stage.sv
// ----------------------------------------------------------------------------
// shift_stage
//   One registered pipeline stage: shifts by 2^STAGE when bit STAGE of the
//   carried shift amount is set, otherwise passes data through. Carries valid,
//   shift amount, mode, captured sign and tag alongside the data.
//   clk/rst_n : clock, async active-low reset
//   advance   : load from the previous stage (else hold)
//   flush     : clear valid
//   in_*      : previous stage outputs;  out_* : this stage's registers
// ----------------------------------------------------------------------------
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned STAGE   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  shift_mode_e        in_mode,
    input  logic               in_sign,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output shift_mode_e        out_mode,
    output logic               out_sign,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int unsigned DIST = 1 << STAGE;

    logic [WIDTH-1:0]   shifted;
    logic               valid_d, valid_q;
    logic [WIDTH-1:0]   data_d,  data_q;
    logic [SHAMT_W-1:0] shamt_d, shamt_q;
    shift_mode_e        mode_d,  mode_q;
    logic               sign_d,  sign_q;
    logic [TAG_W-1:0]   tag_d,   tag_q;

    // SRA fills from the sign captured at accept, not from the current MSB,
    // so the fill stays correct once earlier stages have already shifted.
    always_comb begin
        shifted = in_data;
        if (in_shamt[STAGE]) begin
            case (in_mode)
                SHIFT_SLL:  shifted = in_data << DIST;
                SHIFT_SRL:  shifted = in_data >> DIST;
                SHIFT_SRA:  shifted = {{DIST{in_sign}}, in_data[WIDTH-1:DIST]};
                SHIFT_ROTL: shifted = {in_data[WIDTH-1-DIST:0], in_data[WIDTH-1:WIDTH-DIST]};
                default:    shifted = in_data;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        tag_d   = tag_q;
        if (advance) begin
            valid_d = in_valid;
            data_d  = shifted;
            shamt_d = in_shamt;
            mode_d  = in_mode;
            sign_d  = in_sign;
            tag_d   = in_tag;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= SHIFT_SLL;
            sign_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_shamt = shamt_q;
    assign out_mode  = mode_q;
    assign out_sign  = sign_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/pipelined_shift_unit.sv
// ----------------------------------------------------------------------------
// pipelined_shift_unit
//   WIDTH-bit barrel shifter (SLL/SRL/SRA/ROTL) built as a clog2(WIDTH)-deep
//   registered pipeline with valid/ready handshake, one op per cycle.
//   Clk     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   Flush   : synchronous discard of all in-flight ops
//   io      : op/result handshake bundle (slave side)
// ----------------------------------------------------------------------------
module pipelined_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input logic                    Clk,
    input logic                    Reset_n,
    input logic                    Flush,
    pipelined_shift_unit_if.slave  io
);
    localparam int unsigned SHAMT_W = clog2(WIDTH);

    logic               advance;
    logic               accept;
    logic [SHAMT_W:0]   vld;
    logic [WIDTH-1:0]   dat [SHAMT_W+1];
    logic [SHAMT_W-1:0] sht [SHAMT_W+1];
    shift_mode_e        mde [SHAMT_W+1];
    logic [SHAMT_W:0]   sgn;
    logic [TAG_W-1:0]   tg  [SHAMT_W+1];
    logic               unused_tail;

    // Global stall: the whole pipeline holds whenever the result is blocked.
    assign advance    = !vld[SHAMT_W] || io.OutReady;
    assign io.InReady = advance && !Flush;
    assign accept     = io.InValid && io.InReady;

    assign vld[0] = accept;
    assign dat[0] = io.InData;
    assign sht[0] = io.InShamt;
    assign mde[0] = shift_mode_e'(io.InMode);
    assign sgn[0] = io.InData[WIDTH-1];
    assign tg[0]  = io.InTag;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        shift_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .TAG_W   (TAG_W),
            .STAGE   (i)
        ) u_stage (
            .clk       (Clk),
            .rst_n     (Reset_n),
            .advance   (advance),
            .flush     (Flush),
            .in_valid  (vld[i]),
            .in_data   (dat[i]),
            .in_shamt  (sht[i]),
            .in_mode   (mde[i]),
            .in_sign   (sgn[i]),
            .in_tag    (tg[i]),
            .out_valid (vld[i+1]),
            .out_data  (dat[i+1]),
            .out_shamt (sht[i+1]),
            .out_mode  (mde[i+1]),
            .out_sign  (sgn[i+1]),
            .out_tag   (tg[i+1])
        );
    end

    assign io.OutValid = vld[SHAMT_W];
    assign io.OutData  = dat[SHAMT_W];
    assign io.OutTag   = tg[SHAMT_W];
    // Decoded from the final data register so it is stable with OutData.
    assign io.OutZero  = (dat[SHAMT_W] == '0);

    // Shift amount, mode and sign are dead after the last stage.
    assign unused_tail = ^{sht[SHAMT_W], mde[SHAMT_W], sgn[SHAMT_W]};

endmodule

// File: tb/tb_pipelined_shift_unit.sv
module tb_pipelined_shift_unit;
    import shift_pkg::*;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned SHAMT_W = 5;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  m;
        logic [31:0] e;
    } vec_t;

    logic Clk;
    logic Reset_n;
    logic Flush;

    pipelined_shift_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    pipelined_shift_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Flush   (Flush),
        .io      (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int   checks    = 0;
    int   failures  = 0;
    int   delivered = 0;
    exp_t exp_q[$];
    logic mon_en    = 1'b0;
    logic held_v    = 1'b0;
    logic [31:0] held_d;
    logic [3:0]  held_t;
    exp_t        mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic [1:0] m);
        case (m)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return 32'($signed(d) >>> s);
            default: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
        endcase
    endfunction

    // Drives one op, waits (bounded) for acceptance and records its result.
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                        input logic [3:0] t, input logic [31:0] e);
        bus.InValid = 1'b1;
        bus.InData  = d;
        bus.InShamt = s;
        bus.InMode  = m;
        bus.InTag   = t;
        for (int n = 0; n < 200; n++) begin
            @(negedge Clk);
            if (bus.InReady) begin
                exp_q.push_back('{d: e, t: t});
                @(posedge Clk);
                #1;
                bus.InValid = 1'b0;
                return;
            end
            @(posedge Clk);
            #1;
        end
        check("send_timeout", 32'd0, 32'd1);
        bus.InValid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge Clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Result monitor: compares every delivered result against the scoreboard,
    // checks hold-stability and InReady while stalled, and flags any output
    // with nothing outstanding.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (held_v) begin
                check("stall_data", bus.OutData, held_d);
                check("stall_tag", 32'(bus.OutTag), 32'(held_t));
            end
            held_v = 1'b0;
            if (exp_q.size() == 0) begin
                check("idle_valid", 32'(bus.OutValid), 32'd0);
            end else if (bus.OutValid) begin
                if (bus.OutReady) begin
                    mon_e = exp_q.pop_front();
                    check("out_data", bus.OutData, mon_e.d);
                    check("out_tag", 32'(bus.OutTag), 32'(mon_e.t));
                    check("out_zero", 32'(bus.OutZero), 32'(mon_e.d == 32'd0));
                    delivered++;
                end else begin
                    check("stall_inready", 32'(bus.InReady), 32'd0);
                    held_v = 1'b1;
                    held_d = bus.OutData;
                    held_t = bus.OutTag;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    vec_t        vecs[14];
    logic [31:0] rd;
    logic [4:0]  rs;
    logic [1:0]  rm;
    logic        rand_done;
    int          base;
    int          lat;

    initial begin
        vecs[0]  = '{d: 32'h0000_0001, s: 5'd31, m: 2'd0, e: 32'h8000_0000};
        vecs[1]  = '{d: 32'h0000_1234, s: 5'd2,  m: 2'd0, e: 32'h0000_48D0};
        vecs[2]  = '{d: 32'h8000_0000, s: 5'd4,  m: 2'd1, e: 32'h0800_0000};
        vecs[3]  = '{d: 32'h8000_0000, s: 5'd4,  m: 2'd2, e: 32'hF800_0000};
        vecs[4]  = '{d: 32'h7000_0000, s: 5'd4,  m: 2'd2, e: 32'h0700_0000};
        vecs[5]  = '{d: 32'h8000_0001, s: 5'd1,  m: 2'd3, e: 32'h0000_0003};
        vecs[6]  = '{d: 32'hA5A5_F00F, s: 5'd0,  m: 2'd0, e: 32'hA5A5_F00F};
        vecs[7]  = '{d: 32'hA5A5_F00F, s: 5'd0,  m: 2'd1, e: 32'hA5A5_F00F};
        vecs[8]  = '{d: 32'h8000_0000, s: 5'd0,  m: 2'd2, e: 32'h8000_0000};
        vecs[9]  = '{d: 32'h0000_0000, s: 5'd0,  m: 2'd3, e: 32'h0000_0000};
        vecs[10] = '{d: 32'h1234_5678, s: 5'd8,  m: 2'd3, e: 32'h3456_7812};
        vecs[11] = '{d: 32'h8000_0000, s: 5'd31, m: 2'd2, e: 32'hFFFF_FFFF};
        vecs[12] = '{d: 32'hFFFF_FFFF, s: 5'd31, m: 2'd1, e: 32'h0000_0001};
        vecs[13] = '{d: 32'h0000_0002, s: 5'd31, m: 2'd0, e: 32'h0000_0000};

        Reset_n      = 1'b0;
        Flush        = 1'b0;
        bus.InValid  = 1'b0;
        bus.InData   = '0;
        bus.InShamt  = '0;
        bus.InMode   = '0;
        bus.InTag    = '0;
        bus.OutReady = 1'b1;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_outvalid", 32'(bus.OutValid), 32'd0);
        check("rst_outzero", 32'(bus.OutZero), 32'd1);
        check("rst_outdata", bus.OutData, 32'd0);
        check("rst_outtag", 32'(bus.OutTag), 32'd0);
        #1;
        Reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge Clk);
        check("rst_inready", 32'(bus.InReady), 32'd1);
        @(posedge Clk);
        #1;

        // Directed vectors, back-to-back
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].d, vecs[i].s, vecs[i].m, 4'(i), vecs[i].e);
        end
        drain();

        // Random ops against random back-pressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    rd = $urandom;
                    rs = 5'($urandom_range(0, 31));
                    rm = 2'($urandom_range(0, 3));
                    send(rd, rs, rm, 4'(i), model(rd, int'(rs), rm));
                end
                rand_done = 1'b1;
            end
            begin
                for (int c = 0; c < 3000 && !rand_done; c++) begin
                    @(posedge Clk);
                    #1;
                    bus.OutReady = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.OutReady = 1'b1;
        drain();

        // Eight back-to-back ops with a 4-cycle consumer stall
        base = delivered;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    rd = 32'hA000_0001 ^ 32'(i << 8);
                    rs = 5'(i * 3);
                    send(rd, rs, 2'd3, 4'(i), model(rd, int'(rs), 2'd3));
                end
            end
            begin
                for (int n = 0; n < 100 && delivered < base + 3; n++) @(negedge Clk);
                @(posedge Clk);
                #1;
                bus.OutReady = 1'b0;
                repeat (4) @(posedge Clk);
                #1;
                bus.OutReady = 1'b1;
            end
        join
        drain();
        check("b2b_count", 32'(delivered - base), 32'd8);

        // Flush with three ops in flight; op presented during flush is refused
        send(32'h0000_0011, 5'd1, 2'd0, 4'h1, 32'h0000_0022);
        send(32'h0000_0011, 5'd2, 2'd0, 4'h2, 32'h0000_0044);
        send(32'h0000_0011, 5'd3, 2'd0, 4'h3, 32'h0000_0088);
        Flush       = 1'b1;
        bus.InValid = 1'b1;
        bus.InData  = 32'h0000_00F0;
        bus.InShamt = 5'd4;
        bus.InMode  = 2'd0;
        bus.InTag   = 4'hC;
        @(negedge Clk);
        check("flush_inready", 32'(bus.InReady), 32'd0);
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        check("post_flush_inready", 32'(bus.InReady), 32'd1);
        exp_q.push_back('{d: 32'h0000_0F00, t: 4'hC});
        @(posedge Clk);
        #1;
        bus.InValid = 1'b0;
        lat = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (bus.OutValid) break;
            lat++;
            @(posedge Clk);
        end
        check("flush_latency", 32'(lat), 32'(SHAMT_W));
        drain();

        // Asynchronous reset in the middle of a stream
        send(32'h0000_0100, 5'd1, 2'd0, 4'h4, 32'h0000_0200);
        send(32'h0000_0100, 5'd2, 2'd0, 4'h5, 32'h0000_0400);
        send(32'h0000_0100, 5'd3, 2'd0, 4'h6, 32'h0000_0800);
        send(32'h0000_0100, 5'd4, 2'd0, 4'h7, 32'h0000_1000);
        @(posedge Clk);
        #1;
        check("pre_reset_valid", 32'(bus.OutValid), 32'd1);
        #1;
        Reset_n = 1'b0;
        exp_q.delete();
        held_v  = 1'b0;
        #1;
        check("mid_rst_outvalid", 32'(bus.OutValid), 32'd0);
        check("mid_rst_outzero", 32'(bus.OutZero), 32'd1);
        check("mid_rst_outdata", bus.OutData, 32'd0);
        @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        #1;
        check("post_rst_inready", 32'(bus.InReady), 32'd1);
        repeat (8) @(posedge Clk);
        #1;
        send(32'h0F00_0000, 5'd4, 2'd3, 4'h9, 32'hF000_0000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
